// File: rtl/data_memory_lsu.sv
`default_nettype none
// ============================================================================
// Module      : data_memory_lsu
// Description : Byte-addressed 32-bit data memory for the MEM stage. Accepts
//               one RV32 load/store request on a valid/ready port and returns
//               a single-cycle response pulse a fixed LATENCY cycles later.
//               Handles little-endian lane selection, sign/zero extension,
//               misalignment / illegal-size / out-of-range errors, and a
//               reset-time preload of the array.
// Ports       : clk, reset          - clock, synchronous active-high reset
//               req_valid/req_ready - request handshake
//               req_we, req_addr, req_size, req_unsigned, req_wdata
//                                   - request fields (captured on accept)
//               rsp_valid           - one-cycle response pulse
//               rsp_rdata, rsp_err  - load data / error flag, valid with pulse
//               busy                - request in flight (== !req_ready)
// Revision    : 1.0 - initial release
// ============================================================================
module data_memory_lsu #(
    parameter int DEPTH      = 1024,
    parameter int LATENCY    = 1,
    parameter int INIT_COUNT = 6,
    parameter int INIT_BASE  = 70
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic        busy
);

    localparam int         IDX_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [3:0] CNT_INIT = (LATENCY >= 2) ? 4'(LATENCY - 2) : 4'd0;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t      r_state, w_state_next;
    logic [3:0]  r_cnt, w_cnt_next;

    logic        r_we;
    logic [31:0] r_addr;
    logic [1:0]  r_size;
    logic        r_unsigned;
    logic [31:0] r_wdata;

    logic [31:0] r_mem [DEPTH];

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
            r_cnt   <= 4'd0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        req_ready    = 1'b0;
        case (r_state)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    if (LATENCY == 1) begin
                        w_state_next = RESP;
                    end else begin
                        w_state_next = WAIT;
                        w_cnt_next   = CNT_INIT;
                    end
                end
            end
            WAIT: begin
                if (r_cnt == 4'd0) begin
                    w_state_next = RESP;
                end else begin
                    w_cnt_next = r_cnt - 4'd1;
                end
            end
            RESP:    w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    assign busy = !req_ready;

    wire w_accept = (r_state == IDLE) && req_valid;
    // Commit happens on the edge that enters RESP; with LATENCY=1 that is the
    // accept edge itself, so the live request fields must be used there.
    wire w_commit = (w_state_next == RESP);

    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_we       <= req_we;
            r_addr     <= req_addr;
            r_size     <= req_size;
            r_unsigned <= req_unsigned;
            r_wdata    <= req_wdata;
        end
    end

    wire        w_idle     = (r_state == IDLE);
    wire        w_f_we     = w_idle ? req_we       : r_we;
    wire [31:0] w_f_addr   = w_idle ? req_addr     : r_addr;
    wire [1:0]  w_f_size   = w_idle ? req_size     : r_size;
    wire        w_f_uns    = w_idle ? req_unsigned : r_unsigned;
    wire [31:0] w_f_wdata  = w_idle ? req_wdata    : r_wdata;

    // ------------------------------------------------------------------
    // Error checks
    // ------------------------------------------------------------------
    wire w_illegal  = (w_f_size == 2'b11);
    wire w_misalign = ((w_f_size == 2'b01) && w_f_addr[0]) ||
                      ((w_f_size == 2'b10) && (w_f_addr[1:0] != 2'b00));
    wire w_oor      = ({2'b00, w_f_addr[31:2]} >= 32'(DEPTH));
    wire w_err      = w_illegal || w_misalign || w_oor;

    wire [IDX_W-1:0] w_idx   = w_f_addr[IDX_W+1:2];
    wire [31:0]      w_rword = w_oor ? 32'd0 : r_mem[w_idx];

    // ------------------------------------------------------------------
    // Load extraction and store lane steering
    // ------------------------------------------------------------------
    logic [7:0]  w_byte;
    logic [15:0] w_half;
    logic [31:0] w_load;
    logic [31:0] w_wrep;
    logic [3:0]  w_bmask;

    always_comb begin
        w_byte  = w_rword[{w_f_addr[1:0], 3'b000} +: 8];
        w_half  = w_f_addr[1] ? w_rword[31:16] : w_rword[15:0];
        w_load  = 32'd0;
        w_wrep  = w_f_wdata;
        w_bmask = 4'b0000;
        case (w_f_size)
            2'b00: begin
                w_load  = w_f_uns ? {24'd0, w_byte} : {{24{w_byte[7]}}, w_byte};
                w_wrep  = {4{w_f_wdata[7:0]}};
                w_bmask = 4'b0001 << w_f_addr[1:0];
            end
            2'b01: begin
                w_load  = w_f_uns ? {16'd0, w_half} : {{16{w_half[15]}}, w_half};
                w_wrep  = {2{w_f_wdata[15:0]}};
                w_bmask = w_f_addr[1] ? 4'b1100 : 4'b0011;
            end
            2'b10: begin
                w_load  = w_rword;
                w_bmask = 4'b1111;
            end
            default: begin
                w_load  = 32'd0;
                w_bmask = 4'b0000;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Storage: full clear plus preload on reset; reset also blocks any
    // pending commit because it takes priority.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[IDX_W'(i)] <= (i < INIT_COUNT) ? 32'(INIT_BASE + i) : 32'd0;
            end
        end else if (w_commit && w_f_we && !w_err) begin
            for (int b = 0; b < 4; b++) begin
                if (w_bmask[b]) begin
                    r_mem[w_idx][8*b +: 8] <= w_wrep[8*b +: 8];
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Response register: loaded entering RESP, zeroed on every other edge
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            rsp_valid <= 1'b0;
            rsp_rdata <= 32'd0;
            rsp_err   <= 1'b0;
        end else begin
            rsp_valid <= w_commit;
            if (w_commit) begin
                rsp_err   <= w_err;
                rsp_rdata <= (w_f_we || w_err) ? 32'd0 : w_load;
            end else begin
                rsp_err   <= 1'b0;
                rsp_rdata <= 32'd0;
            end
        end
    end

endmodule
`default_nettype wire
